// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared state encoding and counter sizing for switch_debouncer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_WHI = 2'd1,
    S_HI  = 2'd2,
    S_WLO = 2'd3
  } deb_state_e;

  // Counter must hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
// debounce_ch : one-bit synchroniser, stability filter FSM and edge strobes
// Rev 1.0 : initial release (toggle flop built only with DEBOUNCE_TOGGLE_EN)
// ============================================================================
`default_nettype none

module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);

  localparam int             CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic          sync_s;

  assign sync_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LO: begin
          if (sync_s) begin
            state_q <= S_WHI;
            cnt_q   <= '0;
          end
        end
        S_WHI: begin
          if (!sync_s) begin
            state_q <= S_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HI: begin
          if (!sync_s) begin
            state_q <= S_WLO;
            cnt_q   <= '0;
          end
        end
        S_WLO: begin
          if (sync_s) begin
            state_q <= S_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  // Flips on the edge that closes each rise-strobe cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      toggle_q <= 1'b0;
    end else if (rise_q) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer : N_CH independent debounced switch channels with strobes
// Rev 1.0 : initial release; optional toggle outputs via DEBOUNCE_TOGGLE_EN
// ============================================================================
`default_nettype none

module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_level,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic [N_CH-1:0] sw_toggle
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_ch (
      .clk_i    (CLK),
      .rst_i    (rst),
      .sw_i     (sw_in[i]),
      .level_o  (sw_level[i]),
      .rise_o   (sw_rise[i]),
      .fall_o   (sw_fall[i]),
      .toggle_o (sw_toggle[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// tb_switch_debouncer : directed and random checks against a window-based model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

  localparam int N_CH = 8;
  localparam int DEB  = 4;

  logic            CLK = 1'b0;
  logic            rst;
  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] sw_level;
  logic [N_CH-1:0] sw_rise;
  logic [N_CH-1:0] sw_fall;
  logic [N_CH-1:0] sw_toggle;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  switch_debouncer #(
    .N_CH       (N_CH),
    .DEB_CYCLES (DEB)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_level  (sw_level),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_toggle (sw_toggle)
  );

  // Model: input seen two edges late; a level flips once the last DEB+1
  // observed samples all disagree with it.
  logic [7:0] m_p0, m_p1, m_level, m_rise, m_fall, m_tog;
  logic [7:0] win[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] in, input logic r);
    logic [7:0] s;
    logic       ok;
    if (r) begin
      m_p0 = 0; m_p1 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_tog = 0;
      win.delete();
    end else begin
`ifdef DEBOUNCE_TOGGLE_EN
      m_tog = m_tog ^ m_rise;
`endif
      s = m_p1; m_p1 = m_p0; m_p0 = in;
      win.push_back(s);
      if (win.size() > DEB + 1) void'(win.pop_front());
      m_rise = 0; m_fall = 0;
      if (win.size() == DEB + 1) begin
        for (int i = 0; i < N_CH; i++) begin
          ok = 1'b1;
          foreach (win[k]) if (win[k][i] == m_level[i]) ok = 1'b0;
          if (ok) begin
            if (m_level[i]) m_fall[i] = 1'b1; else m_rise[i] = 1'b1;
            m_level[i] = ~m_level[i];
          end
        end
      end
    end
  endtask

  task automatic step(input logic [7:0] in, input logic r);
    sw_in = in;
    rst   = r;
    @(posedge CLK);
    model_edge(in, r);
    #1;
    check("level", sw_level, m_level);
    check("rise", sw_rise, m_rise);
    check("fall", sw_fall, m_fall);
    check("toggle", sw_toggle, m_tog);
    check("rise_fall_excl", sw_rise & sw_fall, 8'h00);
  endtask

  initial begin : main
    logic [7:0] cur;
    logic [7:0] mask;
    logic [7:0] seen;
    logic [7:0] tog_exp;
    m_p0 = 0; m_p1 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_tog = 0;
    sw_in = 8'h00;
    rst   = 1'b1;

    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("reset_level", sw_level, 8'h00);
    check("reset_strobes", sw_rise | sw_fall | sw_toggle, 8'h00);
    for (int k = 0; k < 4; k++) step(8'h00, 1'b0);

    // Clean rise on channel 0
    for (int k = 1; k <= 6; k++) step(8'h01, 1'b0);
    check("rise0_early", {7'b0, sw_level[0]}, 8'h00);
    step(8'h01, 1'b0);
    check("rise0_level", {7'b0, sw_level[0]}, 8'h01);
    check("rise0_strobe", {7'b0, sw_rise[0]}, 8'h01);
    step(8'h01, 1'b0);
    check("rise0_strobe_off", {7'b0, sw_rise[0]}, 8'h00);

    // Glitch on channel 1
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      step(8'h03, 1'b0);
      seen |= {5'b0, sw_level[1], sw_rise[1], sw_fall[1]};
    end
    for (int k = 0; k < 10; k++) begin
      step(8'h01, 1'b0);
      seen |= {5'b0, sw_level[1], sw_rise[1], sw_fall[1]};
    end
    check("glitch_ch1", seen, 8'h00);

    // Clean fall on channel 0
    for (int k = 1; k <= 6; k++) step(8'h00, 1'b0);
    check("fall0_early", {7'b0, sw_level[0]}, 8'h01);
    step(8'h00, 1'b0);
    check("fall0_level", {7'b0, sw_level[0]}, 8'h00);
    check("fall0_strobe", {7'b0, sw_fall[0]}, 8'h01);
    step(8'h00, 1'b0);
    check("fall0_strobe_off", {7'b0, sw_fall[0]}, 8'h00);

    // All channels together
    for (int k = 1; k <= 6; k++) step(8'hFF, 1'b0);
    check("all_rise_early", sw_rise, 8'h00);
    step(8'hFF, 1'b0);
    check("all_rise", sw_rise, 8'hFF);
    check("all_level", sw_level, 8'hFF);
    for (int k = 0; k < 10; k++) step(8'h00, 1'b0);
    check("all_fallen", sw_level, 8'h00);

    // Reset mid-count on channel 2
    seen = 0;
    for (int k = 1; k <= 3; k++) begin
      step(8'h04, 1'b0);
      seen |= sw_rise | sw_fall;
    end
    step(8'h04, 1'b1);
    seen |= sw_rise | sw_fall | sw_level;
    check("midcount_no_strobe", seen, 8'h00);
    for (int k = 1; k <= 6; k++) step(8'h04, 1'b0);
    check("post_rst_early", sw_rise, 8'h00);
    step(8'h04, 1'b0);
    check("post_rst_rise", sw_rise, 8'h04);

    // Three presses on channel 3
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 9; k++) step(8'h08, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
      tog_exp = (p == 1) ? 8'h00 : 8'h01;
`else
      tog_exp = 8'h00;
`endif
      check("toggle_ch3", {7'b0, sw_toggle[3]}, tog_exp);
      for (int k = 0; k < 9; k++) step(8'h00, 1'b0);
    end

    // Random: alternating calm and bouncy phases, rare resets
    cur = 8'h00;
    for (int n = 0; n < 600; n++) begin
      mask = 0;
      for (int b = 0; b < N_CH; b++) begin
        if ((n % 100) < 60) begin
          if ($urandom_range(0, 15) == 0) mask[b] = 1'b1;
        end else begin
          if ($urandom_range(0, 1) == 0) mask[b] = 1'b1;
        end
      end
      cur ^= mask;
      step(cur, ($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
